// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin scheduler sharing one 16-bit SPI frame engine among NUM_REQ requesters.
// Grants one requester, launches the frame, returns the received word, then enforces an idle gap.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to abort frames that never report spi_done.
module spi_xfer_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       spi_start,
  output logic [DATA_W-1:0]          spi_tx,
  input  logic                       spi_busy,
  input  logic                       spi_done,
  input  logic [DATA_W-1:0]          spi_rx,
  output logic                       timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP,
    GAP
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;
`endif

  // Index base+off modulo NUM_REQ; works for non-power-of-two requester counts
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_W'(sum);
  endfunction

  // Round-robin search: first set req bit starting at ptr and wrapping past NUM_REQ-1
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[wrap_idx(ptr, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(ptr, k);
      end
    end
  end

  // Transaction FSM; every output is registered so grant, launch and response are glitch-free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      spi_start <= 1'b0;
      spi_tx    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      spi_start <= 1'b0;
      rsp_valid <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt    <= NUM_REQ'(1) << pick_idx;
            gnt_id <= pick_idx;
            spi_tx <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!req[gnt_id]) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (!spi_busy) begin
            spi_start <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (spi_done) begin
            rsp_data  <= spi_rx;
            rsp_valid <= gnt;
            state     <= RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
            rsp_data    <= '1;
            rsp_valid   <= gnt;
            timeout_err <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          ptr <= wrap_idx(gnt_id, 1);
          gnt <= '0;
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_W'(GAP_CYCLES - 1);
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SPI_ARB_TIMEOUT_EN
  // Watchdog absent: error output tied low, limit parameter only folded into an unused net
  logic unused_timeout;
  assign unused_timeout = ^8'(TIMEOUT_CYCLES);
  assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: scoreboard bench for spi_xfer_arbiter with a simple SPI master model.
// Honours SPI_ARB_TIMEOUT_EN for the watchdog scenario.
module tb_spi_xfer_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int DATA_W         = 16;
  localparam int GAP_CYCLES     = 4;
  localparam int TIMEOUT_CYCLES = 255;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [1:0]                gnt_id;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      spi_start;
  logic [DATA_W-1:0]         spi_tx;
  logic                      spi_busy;
  logic                      spi_done;
  logic [DATA_W-1:0]         spi_rx;
  logic                      timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] words [4] = '{16'h1231, 16'h2452, 16'h1264, 16'hA234};

  spi_xfer_arbiter #(
    .NUM_REQ(NUM_REQ),
    .DATA_W(DATA_W),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .spi_start(spi_start),
    .spi_tx(spi_tx),
    .spi_busy(spi_busy),
    .spi_done(spi_done),
    .spi_rx(spi_rx),
    .timeout_err(timeout_err)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Rising-edge counter used for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a scenario wedges
  initial begin
    #200us;
    $display("[TB] FAIL watchdog: time limit reached before summary (checks=%0d)", checks);
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic set_word(input int id, input logic [15:0] w);
    req_data[id*DATA_W +: DATA_W] = w;
  endtask

  task automatic apply_reset();
    rst      = 1'b0;
    req      = '0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = '0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for spi_start; returns at the negedge where it is seen
  task automatic wait_start(input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // SPI master model: busy for len cycles, then a one-cycle done with rx; returns where rsp is due
  task automatic finish_frame(input logic [15:0] rx, input int len, output int done_cyc);
    spi_busy = 1'b1;
    repeat (len - 1) @(negedge clk);
    spi_done = 1'b1;
    spi_rx   = rx;
    spi_busy = 1'b0;
    done_cyc = cyc;
    @(negedge clk);
    spi_done = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({gnt, gnt_id, rsp_valid, rsp_data, spi_start, spi_tx, timeout_err} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: gnt=%b id=%0d rsp_valid=%b rsp_data=%h start=%b tx=%h terr=%b, all required 0",
               gnt, gnt_id, rsp_valid, rsp_data, spi_start, spi_tx, timeout_err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || spi_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: gnt=%b start=%b, required 0000/0", gnt, spi_start);
    end
    spi_rx   = 16'h1234;
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0000 || rsp_data !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL done_outside_wait: rsp_valid=%b rsp_data=%h, required 0000/0000", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_single();
    exp_t e;
    int   dc;
    apply_reset();
    set_word(0, 16'h1231);
    req = 4'b0001;
    sb_q.push_back(exp_t'{id: 0, data: 16'hA5A5});
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || spi_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant: gnt=%b id=%0d start=%b, required 0001/0/0", gnt, gnt_id, spi_start);
    end
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b1 || spi_tx !== 16'h1231) begin
      errors++;
      $display("[TB] FAIL single_start: start=%b tx=%h, required 1/1231", spi_start, spi_tx);
    end
    @(negedge clk);
    checks++;
    if (spi_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_start_pulse: start=%b one cycle later, required 0", spi_start);
    end
    finish_frame(16'hA5A5, 19, dc);
    req = 4'b0000;
    e   = sb_q.pop_front();
    checks++;
    if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
      errors++;
      $display("[TB] FAIL single_rsp: rsp_valid=%b rsp_data=%h, required %b/%h", rsp_valid, rsp_data, 4'(1 << e.id), e.data);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 4'b0000 || gnt !== 4'b0000 || rsp_data !== 16'hA5A5) begin
      errors++;
      $display("[TB] FAIL single_after: rsp_valid=%b gnt=%b rsp_data=%h, required 0000/0000/a5a5", rsp_valid, gnt, rsp_data);
    end
  endtask

  task automatic test_round_robin();
    exp_t        e;
    bit          found;
    int          prev_done;
    int          exp_id;
    logic [15:0] rx;
    apply_reset();
    for (int i = 0; i < 4; i++) set_word(i, words[i]);
    req       = 4'b1111;
    prev_done = 0;
    for (int f = 0; f < 5; f++) begin
      exp_id = f % 4;
      rx     = 16'h5A00 + 16'(f);
      sb_q.push_back(exp_t'{id: exp_id, data: rx});
      wait_start(40, found);
      checks++;
      if (!found) begin
        errors++;
        $display("[TB] FAIL rr_start_%0d: no spi_start within 40 cycles, required a launch", f);
        req = '0;
        return;
      end
      checks++;
      if (gnt_id !== 2'(exp_id) || gnt !== 4'(1 << exp_id) || spi_tx !== words[exp_id]) begin
        errors++;
        $display("[TB] FAIL rr_grant_%0d: id=%0d gnt=%b tx=%h, required %0d/%b/%h",
                 f, gnt_id, gnt, spi_tx, exp_id, 4'(1 << exp_id), words[exp_id]);
      end
      if (f > 0) begin
        // done cycle, RESP, GAP_CYCLES of gap, IDLE grant, LAUNCH -> start visible GAP_CYCLES+4 edges later
        checks++;
        if (cyc - prev_done !== GAP_CYCLES + 4) begin
          errors++;
          $display("[TB] FAIL rr_gap_%0d: done-to-start %0d cycles, required %0d", f, cyc - prev_done, GAP_CYCLES + 4);
        end
      end
      finish_frame(rx, 6, prev_done);
      if (f == 4) req = 4'b0000;
      e = sb_q.pop_front();
      checks++;
      if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
        errors++;
        $display("[TB] FAIL rr_rsp_%0d: rsp_valid=%b rsp_data=%h, required %b/%h", f, rsp_valid, rsp_data, 4'(1 << e.id), e.data);
      end
    end
  endtask

  task automatic test_withdraw();
    exp_t e;
    bit   found;
    bit   bad;
    int   dc;
    apply_reset();
    spi_busy = 1'b1;
    set_word(2, 16'h1264);
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL wd_grant: gnt=%b id=%0d, required 0100/2", gnt, gnt_id);
    end
    req = 4'b0000;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (spi_start !== 1'b0 || gnt !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL wd_drop: start=%b gnt=%b seen after withdrawal, required 0/0000", spi_start, gnt);
    end
    checks++;
    if (gnt_id !== 2'd2) begin
      errors++;
      $display("[TB] FAIL wd_id_kept: id=%0d, required 2", gnt_id);
    end
    set_word(1, 16'h2452);
    set_word(3, 16'hA234);
    req = 4'b1010;
    @(negedge clk);
    checks++;
    if (gnt_id !== 2'd1 || gnt !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL wd_ptr_kept: id=%0d gnt=%b, required 1/0010", gnt_id, gnt);
    end
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (spi_start !== 1'b0 || gnt !== 4'b0010) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL busy_hold: start=%b gnt=%b while busy, required 0/0010", spi_start, gnt);
    end
    spi_busy = 1'b0;
    sb_q.push_back(exp_t'{id: 1, data: 16'h3C3C});
    wait_start(3, found);
    checks++;
    if (!found || spi_tx !== 16'h2452) begin
      errors++;
      $display("[TB] FAIL busy_release: start_seen=%b tx=%h, required 1/2452", found, spi_tx);
    end
    if (found) begin
      finish_frame(16'h3C3C, 5, dc);
      req = 4'b0000;
      e   = sb_q.pop_front();
      checks++;
      if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
        errors++;
        $display("[TB] FAIL wd_rsp: rsp_valid=%b rsp_data=%h, required %b/%h", rsp_valid, rsp_data, 4'(1 << e.id), e.data);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit   found;
    bit   bad;
    int   dc;
    apply_reset();
    set_word(1, 16'h2452);
    req = 4'b0010;
    sb_q.push_back(exp_t'{id: 1, data: 16'h1111});
    wait_start(5, found);
    finish_frame(16'h1111, 4, dc);
    req = 4'b0000;
    e   = sb_q.pop_front();
    checks++;
    if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
      errors++;
      $display("[TB] FAIL mr_first_rsp: rsp_valid=%b rsp_data=%h, required %b/%h", rsp_valid, rsp_data, 4'(1 << e.id), e.data);
    end
    repeat (6) @(negedge clk);
    set_word(3, 16'hA234);
    req = 4'b1000;
    wait_start(10, found);
    checks++;
    if (!found || gnt_id !== 2'd3) begin
      errors++;
      $display("[TB] FAIL mr_launch: start_seen=%b id=%0d, required 1/3", found, gnt_id);
    end
    spi_busy = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_id, rsp_valid, rsp_data, spi_start, spi_tx, timeout_err} !== '0) begin
      errors++;
      $display("[TB] FAIL mr_async_clear: gnt=%b id=%0d rsp_valid=%b rsp_data=%h start=%b tx=%h terr=%b, all required 0",
               gnt, gnt_id, rsp_valid, rsp_data, spi_start, spi_tx, timeout_err);
    end
    spi_busy = 1'b0;
    req      = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid !== 4'b0000 || spi_start !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("[TB] FAIL mr_dropped: rsp_valid=%b start=%b after reset, required 0000/0", rsp_valid, spi_start);
    end
    set_word(0, 16'h1231);
    req = 4'b1001;
    sb_q.push_back(exp_t'{id: 0, data: 16'h7E7E});
    wait_start(5, found);
    checks++;
    if (!found || gnt_id !== 2'd0 || spi_tx !== 16'h1231) begin
      errors++;
      $display("[TB] FAIL mr_ptr_reset: start_seen=%b id=%0d tx=%h, required 1/0/1231", found, gnt_id, spi_tx);
    end
    if (found) begin
      finish_frame(16'h7E7E, 3, dc);
      req = 4'b0000;
      e   = sb_q.pop_front();
      checks++;
      if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
        errors++;
        $display("[TB] FAIL mr_rsp: rsp_valid=%b rsp_data=%h, required %b/%h", rsp_valid, rsp_data, 4'(1 << e.id), e.data);
      end
    end
  endtask

  task automatic test_timeout();
    bit found;
    apply_reset();
    set_word(2, 16'h1264);
    req = 4'b0100;
    wait_start(5, found);
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL to_start: no spi_start within 5 cycles, required a launch");
    end
`ifdef SPI_ARB_TIMEOUT_EN
    begin
      exp_t e;
      int   s;
      bit   got;
      s   = cyc;
      got = 1'b0;
      sb_q.push_back(exp_t'{id: 2, data: 16'hFFFF});
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (rsp_valid !== 4'b0000 || timeout_err !== 1'b0) begin
          got = 1'b1;
          break;
        end
      end
      checks++;
      if (!got || cyc - s !== TIMEOUT_CYCLES || timeout_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL to_pulse: seen=%b after %0d cycles terr=%b, required 1 after %0d cycles with terr=1",
                 got, cyc - s, timeout_err, TIMEOUT_CYCLES);
      end
      e = sb_q.pop_front();
      checks++;
      if (rsp_valid !== 4'(1 << e.id) || rsp_data !== e.data) begin
        errors++;
        $display("[TB] FAIL to_rsp: rsp_valid=%b rsp_data=%h, required %b/%h", rsp_valid, rsp_data, 4'(1 << e.id), e.data);
      end
      req = 4'b0000;
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || rsp_valid !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL to_pulse_len: terr=%b rsp_valid=%b one cycle later, required 0/0000", timeout_err, rsp_valid);
      end
    end
`else
    begin
      bit bad;
      bad = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (rsp_valid !== 4'b0000 || timeout_err !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad || gnt !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL no_timeout: response_seen=%b gnt=%b, required 0/0100 (waiting forever)", bad, gnt);
      end
      apply_reset();
    end
`endif
  endtask

  // Scenario sequence
  initial begin
    rst      = 1'b0;
    req      = '0;
    req_data = '0;
    spi_busy = 1'b0;
    spi_done = 1'b0;
    spi_rx   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_mid_reset();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
